// File: rtl/ctrl_input_pkg.sv
// Shared game constants: control-vector width and bit positions used by
// ctrl_input and the sprite movement FSMs.
package ctrl_input_pkg;

  localparam int CTRL_W     = 6;

  localparam int CTRL_LEFT  = 0;
  localparam int CTRL_RIGHT = 1;
  localparam int CTRL_UP    = 2;
  localparam int CTRL_DOWN  = 3;
  localparam int CTRL_JUMP  = 4;
  localparam int CTRL_ACT   = 5;

endpackage

// File: rtl/ctrl_input_btn_debounce.sv
// One button: two-flop synchronizer followed by a consecutive-cycle debounce
// counter that flips the stable level only after an unbroken disagreement run.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 40000
) (
  input  logic i_clk_pix,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      cnt      <= '0;
      o_stable <= 1'b0;
    end else begin
      sync_p0 <= i_btn;
      sync_p1 <= sync_p0;
      // Debounce stage: the >= compare keeps the counter from ever wrapping.
      if (sync_p1 == o_stable) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        o_stable <= sync_p1;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctrl_input.sv
// Debounced, conflict-resolved button vector, updated once per frame, with a
// one-frame jump pulse per press.
module ctrl_input #(
  parameter int DEBOUNCE_CYCLES = 40000,
  parameter int CTRL_W          = ctrl_input_pkg::CTRL_W
) (
  input  logic              i_clk_pix,
  input  logic              i_rst_n,
  input  logic [CTRL_W-1:0] i_btn,
  input  logic              i_frame,
  output logic [CTRL_W-1:0] o_ctrl
);

  import ctrl_input_pkg::*;

  logic [CTRL_W-1:0] stable;
  logic              jump_d_p0;
  logic              jump_pend;
  logic              jump_rise;

  for (genvar g = 0; g < CTRL_W; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .i_clk_pix(i_clk_pix),
      .i_rst_n  (i_rst_n),
      .i_btn    (i_btn[g]),
      .o_stable (stable[g])
    );
  end

  // Opposing directions: right beats left, up beats down.
  function automatic logic [CTRL_W-1:0] resolve(input logic [CTRL_W-1:0] lvl,
                                                input logic              jump);
    logic [CTRL_W-1:0] r;
    r            = lvl;
    r[CTRL_LEFT] = lvl[CTRL_LEFT] & ~lvl[CTRL_RIGHT];
    r[CTRL_DOWN] = lvl[CTRL_DOWN] & ~lvl[CTRL_UP];
    r[CTRL_JUMP] = jump;
    return r;
  endfunction

  assign jump_rise = stable[CTRL_JUMP] & ~jump_d_p0;

  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      jump_d_p0 <= 1'b0;
      jump_pend <= 1'b0;
      o_ctrl    <= '0;
    end else begin
      jump_d_p0 <= stable[CTRL_JUMP];
      // Frame stage: an edge landing on the frame cycle goes straight out.
      if (i_frame) begin
        o_ctrl    <= resolve(stable, jump_pend | jump_rise);
        jump_pend <= 1'b0;
      end else if (jump_rise) begin
        jump_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_input.sv
// Randomized and directed bench for ctrl_input against a history-window model.
module tb_ctrl_input;

  import ctrl_input_pkg::*;

  localparam int DEB   = 4;
  localparam int FRAME = 50;

  logic        clk;
  logic        i_rst_n;
  logic [5:0]  i_btn;
  logic        i_frame;
  logic [5:0]  o_ctrl;

  int n_cmp = 0;
  int n_bad = 0;
  int ecnt  = 0;

  ctrl_input #(
    .DEBOUNCE_CYCLES(DEB),
    .CTRL_W         (6)
  ) u_dut (
    .i_clk_pix(clk),
    .i_rst_n  (i_rst_n),
    .i_btn    (i_btn),
    .i_frame  (i_frame),
    .o_ctrl   (o_ctrl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame pulse is sampled high at every edge whose index is a multiple of FRAME.
  initial begin
    i_frame = 1'b0;
    forever begin
      @(posedge clk);
      ecnt++;
      #2 i_frame = ((ecnt + 1) % FRAME == 0);
    end
  end

  // Reference model: raw level reaches the debouncer 2 samples late; the
  // stable level flips when the last DEB delivered samples all disagree.
  logic [5:0] m_s0, m_s1, m_cur, m_prev, m_oct;
  logic       m_pend;
  logic [5:0] m_hist [DEB];

  function automatic logic [5:0] m_resolve(input logic [5:0] lvl, input logic j);
    logic [5:0] r;
    r[CTRL_LEFT]  = lvl[CTRL_LEFT] && !lvl[CTRL_RIGHT];
    r[CTRL_RIGHT] = lvl[CTRL_RIGHT];
    r[CTRL_UP]    = lvl[CTRL_UP];
    r[CTRL_DOWN]  = lvl[CTRL_DOWN] && !lvl[CTRL_UP];
    r[CTRL_JUMP]  = j;
    r[CTRL_ACT]   = lvl[CTRL_ACT];
    return r;
  endfunction

  task automatic model_step();
    logic       rise;
    logic [5:0] nxt;
    logic       all_diff;
    if (!i_rst_n) begin
      m_s0 = '0; m_s1 = '0; m_cur = '0; m_prev = '0; m_oct = '0; m_pend = 1'b0;
      for (int k = 0; k < DEB; k++) m_hist[k] = '0;
    end else begin
      rise = m_cur[CTRL_JUMP] && !m_prev[CTRL_JUMP];
      if (i_frame) begin
        m_oct  = m_resolve(m_cur, m_pend || rise);
        m_pend = 1'b0;
      end else if (rise) begin
        m_pend = 1'b1;
      end
      for (int k = DEB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_s1;
      nxt = m_cur;
      for (int b = 0; b < 6; b++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++) if (m_hist[k][b] == m_cur[b]) all_diff = 1'b0;
        if (all_diff) nxt[b] = !m_cur[b];
      end
      m_prev = m_cur;
      m_cur  = nxt;
      m_s1   = m_s0;
      m_s0   = i_btn;
    end
  endtask

  initial begin
    m_s0 = '0; m_s1 = '0; m_cur = '0; m_prev = '0; m_oct = '0; m_pend = 1'b0;
    for (int k = 0; k < DEB; k++) m_hist[k] = '0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until just after the edge whose index mod FRAME equals ph.
  task automatic wait_phase(input int ph);
    for (int c = 0; c < FRAME + 1; c++) begin
      step();
      if (ecnt % FRAME == ph) break;
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_btn   = 6'b111111;
    for (int c = 0; c < 4; c++) step();
    n_cmp++;
    if (o_ctrl !== 6'b0) begin
      n_bad++; $display("FAIL reset_octrl: got %b want %b", o_ctrl, 6'b0);
    end
    n_cmp++;
    if (u_dut.stable !== 6'b0) begin
      n_bad++; $display("FAIL reset_stable: got %b want %b", u_dut.stable, 6'b0);
    end
    i_btn = '0;
    step();
    i_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (o_ctrl !== m_oct || o_ctrl !== 6'b0) begin
        n_bad++; $display("FAIL reset_release: got %b want %b", o_ctrl, 6'b0);
      end
    end
  endtask

  task automatic test_clean_press();
    int  lat;
    bit  seen;
    wait_phase(1);
    i_btn[CTRL_RIGHT] = 1'b1;
    lat  = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      lat++;
      if (u_dut.stable[CTRL_RIGHT]) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || lat != 2 + DEB) begin
      n_bad++; $display("FAIL press_latency: got %0d (seen=%0d) want %0d", lat, seen, 2 + DEB);
    end
    for (int c = 0; c < FRAME + 1; c++) begin
      n_cmp++;
      if (o_ctrl !== m_oct) begin
        n_bad++; $display("FAIL press_track: got %b want %b", o_ctrl, m_oct);
      end
      if (ecnt % FRAME == 0) break;
      step();
    end
    n_cmp++;
    if (o_ctrl !== 6'b000010) begin
      n_bad++; $display("FAIL press_frame: got %b want %b", o_ctrl, 6'b000010);
    end
  endtask

  task automatic test_bounce();
    i_btn = '0;
    for (int c = 0; c < 2 * FRAME + 10; c++) step();
    n_cmp++;
    if (o_ctrl !== 6'b0) begin
      n_bad++; $display("FAIL bounce_pre: got %b want %b", o_ctrl, 6'b0);
    end
    for (int c = 0; c < 40 + 2 * FRAME; c++) begin
      i_btn[CTRL_RIGHT] = (c < 40) ? logic'((c / 2) % 2) : 1'b0;
      step();
      n_cmp++;
      if (o_ctrl !== 6'b0 || o_ctrl !== m_oct) begin
        n_bad++; $display("FAIL bounce: got %b want %b", o_ctrl, 6'b0);
      end
    end
  endtask

  task automatic test_priority();
    logic [5:0] pat [3];
    logic [5:0] exp [3];
    pat[0] = 6'b001111; exp[0] = 6'b000110;
    pat[1] = 6'b100011; exp[1] = 6'b100010;
    pat[2] = 6'b001100; exp[2] = 6'b000100;
    for (int p = 0; p < 3; p++) begin
      i_btn = pat[p];
      for (int c = 0; c < 2 * FRAME + 10; c++) begin
        step();
        n_cmp++;
        if (o_ctrl !== m_oct) begin
          n_bad++; $display("FAIL prio_track%0d: got %b want %b", p, o_ctrl, m_oct);
        end
      end
      n_cmp++;
      if (o_ctrl !== exp[p]) begin
        n_bad++; $display("FAIL prio%0d: got %b want %b", p, o_ctrl, exp[p]);
      end
    end
    i_btn = '0;
    for (int c = 0; c < 2 * FRAME + 10; c++) step();
  endtask

  task automatic test_jump_hold();
    int hi;
    for (int ph = 0; ph < 2; ph++) begin
      wait_phase(1);
      i_btn = 6'b010000;
      hi = 0;
      for (int c = 0; c < 300 + 2 * FRAME; c++) begin
        if (c == 300) i_btn = '0;
        step();
        if (o_ctrl[CTRL_JUMP]) hi++;
        n_cmp++;
        if (o_ctrl !== m_oct) begin
          n_bad++; $display("FAIL jump_hold_track: got %b want %b", o_ctrl, m_oct);
        end
      end
      n_cmp++;
      if (hi != FRAME) begin
        n_bad++; $display("FAIL jump_hold%0d: high cycles %0d want %0d", ph, hi, FRAME);
      end
    end
  endtask

  task automatic test_short_jump();
    wait_phase(10);
    i_btn = 6'b010000;
    for (int c = 0; c < 8; c++) step();
    i_btn = '0;
    for (int c = 0; c < FRAME + 1; c++) begin
      if (ecnt % FRAME == 0) break;
      step();
    end
    n_cmp++;
    if (o_ctrl[CTRL_JUMP] !== 1'b1) begin
      n_bad++; $display("FAIL short_jump: got %b want 1", o_ctrl[CTRL_JUMP]);
    end
    for (int c = 0; c < FRAME; c++) step();
    n_cmp++;
    if (o_ctrl !== 6'b0) begin
      n_bad++; $display("FAIL short_jump_next: got %b want %b", o_ctrl, 6'b0);
    end
  endtask

  task automatic test_coincident();
    wait_phase(FRAME - 7);
    i_btn = 6'b010000;
    for (int c = 0; c < 7; c++) step();
    n_cmp++;
    if (ecnt % FRAME != 0 || o_ctrl[CTRL_JUMP] !== 1'b1) begin
      n_bad++; $display("FAIL coincident: got %b at phase %0d want 1", o_ctrl[CTRL_JUMP], ecnt % FRAME);
    end
    for (int c = 0; c < FRAME; c++) step();
    n_cmp++;
    if (o_ctrl[CTRL_JUMP] !== 1'b0) begin
      n_bad++; $display("FAIL coincident_next: got %b want 0", o_ctrl[CTRL_JUMP]);
    end
    i_btn = '0;
    for (int c = 0; c < 2 * FRAME; c++) step();
  endtask

  task automatic test_reset_mid();
    wait_phase(10);
    i_btn = 6'b010000;
    for (int c = 0; c < 8; c++) step();
    i_btn = 6'b010010;
    for (int c = 0; c < 3; c++) step();
    n_cmp++;
    if (u_dut.jump_pend !== 1'b1) begin
      n_bad++; $display("FAIL mid_pending: got %b want 1", u_dut.jump_pend);
    end
    i_rst_n = 1'b0;
    step();
    step();
    i_btn = '0;
    step();
    i_rst_n = 1'b1;
    for (int c = 0; c < 2 * FRAME + 5; c++) begin
      step();
      n_cmp++;
      if (o_ctrl !== 6'b0 || o_ctrl !== m_oct) begin
        n_bad++; $display("FAIL reset_mid: got %b want %b", o_ctrl, 6'b0);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 2000; c++) begin
      if (hold == 0) begin
        i_btn = 6'($urandom);
        hold  = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 90) : $urandom_range(1, 8);
      end
      hold--;
      i_rst_n = ($urandom_range(0, 399) != 0);
      step();
      n_cmp++;
      if (o_ctrl !== m_oct) begin
        n_bad++; $display("FAIL random c=%0d: got %b want %b", c, o_ctrl, m_oct);
      end
    end
    i_rst_n = 1'b1;
    i_btn   = '0;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_btn   = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_priority();
    test_jump_hold();
    test_short_jump();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
